// File: rtl/scpad_pkg.sv
// Shared scratchpad definitions: request tag width, latency ceiling and bank FSM states.
package scpad_pkg;

  localparam int SCPAD_ID_WIDTH = 4;
  localparam int MAX_SRAM_DELAY = 8;

  typedef enum logic [1:0] {
    BANK_IDLE  = 2'd0,
    BANK_WRITE = 2'd1,
    BANK_READ  = 2'd2
  } bank_state_e;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scpad_sram_array.sv
// Row storage for one scratchpad bank: per-lane masked write, registered read, no reset.
module scpad_sram_array #(
  parameter int LANES  = 32,
  parameter int LANE_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic [LANES-1:0]        wmask,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [LANES*LANE_W-1:0] rdata
);

  // One narrow array per lane so each maps onto a block RAM column with its own write enable.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we && wmask[gi]) begin
        mem[waddr] <= wdata[gi*LANE_W +: LANE_W];
      end
      if (re) begin
        rd_reg <= mem[raddr];
      end
    end

    assign rdata[gi*LANE_W +: LANE_W] = rd_reg;
  end

endmodule

// File: rtl/scpad_sram_bank.sv
// Single-ported scratchpad bank: round-robin write/read arbitration, fixed occupancy, tagged read response.
// Define SCPAD_BANK_PARITY_EN to store one even-parity bit per lane and flag mismatches on rsp_err.
module scpad_sram_bank
  import scpad_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      wr_valid,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [LANES*ELEM_W-1:0]   wr_data,
  input  logic [LANES-1:0]          wr_mask,
  input  logic                      rd_valid,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  input  logic [SCPAD_ID_WIDTH-1:0] rd_id,
  output logic                      busy,
  output logic                      rsp_valid,
  output logic [LANES*ELEM_W-1:0]   rsp_data,
  output logic [SCPAD_ID_WIDTH-1:0] rsp_id,
  output logic                      rsp_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = lat_max(RD_LAT, WR_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
`ifdef SCPAD_BANK_PARITY_EN
  localparam int PAR_W   = 1;
`else
  localparam int PAR_W   = 0;
`endif
  localparam int SW      = ELEM_W + PAR_W;

  bank_state_e               state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic                      last_wr_reg, last_wr_next;
  logic [SCPAD_ID_WIDTH-1:0] id_reg, id_next;
  logic                      grant_wr, grant_rd;

  logic [LANES*SW-1:0]       store_wdata;
  logic [LANES*SW-1:0]       store_rdata;
  logic [LANES*ELEM_W-1:0]   rd_lanes;
  logic                      any_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= BANK_IDLE;
      cnt_reg     <= '0;
      last_wr_reg <= 1'b0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      last_wr_reg <= last_wr_next;
      id_reg      <= id_next;
    end
  end

  // A write with an all-zero mask is not a request; contention goes to the type not granted last.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    last_wr_next = last_wr_reg;
    id_next      = id_reg;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    unique case (state_reg)
      BANK_IDLE: begin
        grant_wr = wr_valid && (|wr_mask) && (!rd_valid || !last_wr_reg);
        grant_rd = rd_valid && !grant_wr;
        if (grant_wr) begin
          state_next   = BANK_WRITE;
          cnt_next     = CNT_W'(WR_LAT);
          last_wr_next = 1'b1;
        end else if (grant_rd) begin
          state_next   = BANK_READ;
          cnt_next     = CNT_W'(RD_LAT);
          last_wr_next = 1'b0;
          id_next      = rd_id;
        end
      end
      BANK_WRITE, BANK_READ: begin
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = BANK_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = BANK_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_reg != BANK_IDLE);
    rsp_valid = (state_reg == BANK_READ) && (cnt_reg == CNT_W'(1));
    rsp_data  = rsp_valid ? rd_lanes : '0;
    rsp_id    = rsp_valid ? id_reg : '0;
    rsp_err   = rsp_valid && any_err;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef SCPAD_BANK_PARITY_EN
    assign store_wdata[gi*SW +: SW] = {^wr_data[gi*ELEM_W +: ELEM_W], wr_data[gi*ELEM_W +: ELEM_W]};
`else
    assign store_wdata[gi*SW +: SW] = wr_data[gi*ELEM_W +: ELEM_W];
`endif
    assign rd_lanes[gi*ELEM_W +: ELEM_W] = store_rdata[gi*SW +: ELEM_W];
  end

`ifdef SCPAD_BANK_PARITY_EN
  // Even parity: data bits plus stored parity bit must XOR to zero in every lane.
  logic [LANES-1:0] lane_err;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_par
    assign lane_err[gi] = ^store_rdata[gi*SW +: SW];
  end
  assign any_err = |lane_err;
`else
  assign any_err = 1'b0;
`endif

  // The read is launched at the accept edge, so data is ready from the first READ cycle onward.
  scpad_sram_array #(
    .LANES  (LANES),
    .LANE_W (SW),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (grant_wr),
    .waddr (wr_addr),
    .wdata (store_wdata),
    .wmask (wr_mask),
    .re    (grant_rd),
    .raddr (rd_addr),
    .rdata (store_rdata)
  );

endmodule

// File: tb/tb_scpad_sram_bank.sv
// Scoreboard bench for scpad_sram_bank: directed stimulus pushes expected responses, a negedge monitor checks them.
module tb_scpad_sram_bank;
  import scpad_pkg::*;

  localparam int LANES  = 32;
  localparam int ELEM_W = 16;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
  localparam int AW     = 6;
  localparam int DW     = LANES * ELEM_W;

  logic                      clk = 1'b0;
  logic                      n_rst;
  logic                      wr_valid;
  logic [AW-1:0]             wr_addr;
  logic [DW-1:0]             wr_data;
  logic [LANES-1:0]          wr_mask;
  logic                      rd_valid;
  logic [AW-1:0]             rd_addr;
  logic [SCPAD_ID_WIDTH-1:0] rd_id;
  logic                      busy;
  logic                      rsp_valid;
  logic [DW-1:0]             rsp_data;
  logic [SCPAD_ID_WIDTH-1:0] rsp_id;
  logic                      rsp_err;

  typedef struct {
    logic [DW-1:0]             data;
    logic [SCPAD_ID_WIDTH-1:0] id;
    logic                      err;
    int                        cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  scpad_sram_bank #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_id     (rd_id),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [ELEM_W-1:0] v);
    return {LANES{v}};
  endfunction

  // Monitor: every response must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_id %0d at cycle %0d, required none", rsp_id, cyc);
      end else begin
        e = sb.pop_front();
        chkd("rsp_data", rsp_data, e.data);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
        $display("[TB] response id=%0d err=%0d cycle=%0d", rsp_id, rsp_err, cyc);
      end
    end else begin
      chk("rsp_idle_zero", {rsp_data != '0, rsp_id != '0, rsp_err}, 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("idle_timeout", busy, 0);
        return;
      end
    end
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] m);
    wait_idle();
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
    $display("[TB] write addr=%0d mask=%h cycle=%0d", a, m, cyc);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    for (int i = 0; i < WR_LAT; i++) begin
      @(negedge clk);
      chk("wr_busy", busy, 1);
    end
    @(negedge clk);
    chk("wr_release", busy, 0);
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [SCPAD_ID_WIDTH-1:0] id,
                       input logic [DW-1:0] d, input logic e);
    exp_t x;
    wait_idle();
    rd_valid = 1'b1;
    rd_addr  = a;
    rd_id    = id;
    x.data = d; x.id = id; x.err = e; x.cyc = cyc + RD_LAT;
    sb.push_back(x);
    $display("[TB] read addr=%0d id=%0d cycle=%0d", a, id, cyc);
    @(posedge clk);
    #1 rd_valid = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clk);
      chk("rd_busy", busy, 1);
    end
    @(negedge clk);
    chk("rd_release", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_d;
    logic [16:0]   busy_pat;
    exp_t          x;
    int            c0;

    n_rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_id = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data_nonzero", rsp_data != '0, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_err", rsp_err, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // Basic write then tagged read.
    do_wr(6'd5, fill(16'h1234), '1);
    do_rd(6'd5, 4'd3, fill(16'h1234), 1'b0);

    // First and last rows.
    do_wr(6'd0, fill(16'h0F0F), '1);
    do_wr(6'd63, fill(16'hBEEF), '1);
    do_rd(6'd63, 4'd1, fill(16'hBEEF), 1'b0);
    do_rd(6'd0, 4'd2, fill(16'h0F0F), 1'b0);

    // Single-lane masked overwrite.
    do_wr(6'd7, fill(16'hFFFF), '1);
    do_wr(6'd7, fill(16'h0000), 32'h0000_0001);
    exp_d = fill(16'hFFFF);
    exp_d[15:0] = 16'h0000;
    do_rd(6'd7, 4'd5, exp_d, 1'b0);

    // Zero-mask write is a no-op.
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = '0; wr_mask = '0;
    @(negedge clk);
    chk("mask0_noop_busy", busy, 0);
    wr_valid = 1'b0;
    do_rd(6'd7, 4'd6, exp_d, 1'b0);

    // A read pulsed while busy must be ignored.
    wait_idle();
    rd_valid = 1'b1; rd_addr = 6'd5; rd_id = 4'd2;
    x.data = fill(16'h1234); x.id = 4'd2; x.err = 1'b0; x.cyc = cyc + RD_LAT;
    sb.push_back(x);
    c0 = cyc;
    $display("[TB] read addr=5 id=2 cycle=%0d (second read pulsed while busy)", cyc);
    @(posedge clk);
    #1 rd_valid = 1'b0;
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = 6'd7; rd_id = 4'd9;
    @(negedge clk);
    rd_valid = 1'b0;
    while (cyc < c0 + RD_LAT + 1) @(negedge clk);
    chk("busy_ignore_release", busy, 0);
    repeat (6) @(negedge clk);
    chk("busy_ignore_still_idle", busy, 0);

    // Reset two cycles into a read: the response is dropped, contents survive.
    wait_idle();
    rd_valid = 1'b1; rd_addr = 6'd5; rd_id = 4'd4;
    $display("[TB] read addr=5 id=4 cycle=%0d (reset mid-read)", cyc);
    @(posedge clk);
    #1 rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    do_rd(6'd5, 4'd7, fill(16'h1234), 1'b0);

    // Contention from reset: write, read, write, read with fixed busy spacing.
    n_rst = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd10; wr_data = fill(16'hAAAA); wr_mask = '1;
    rd_valid = 1'b1; rd_addr = 6'd10; rd_id = 4'd6;
    @(negedge clk);
    n_rst = 1'b1;
    c0 = cyc;
    $display("[TB] contention start cycle=%0d", cyc);
    x.data = fill(16'hAAAA); x.id = 4'd6; x.err = 1'b0; x.cyc = c0 + 3 + RD_LAT;
    sb.push_back(x);
    x.data = fill(16'h5555); x.id = 4'd6; x.err = 1'b0; x.cyc = c0 + 11 + RD_LAT;
    sb.push_back(x);
    busy_pat = 17'b0_1111_0110_1111_0110;
    for (int k = 0; k < 17; k++) begin
      chk("contention_busy", busy, busy_pat[k]);
      if (k == 1) wr_data = fill(16'h5555);
      if (k == 16) begin
        wr_valid = 1'b0;
        rd_valid = 1'b0;
      end
      @(negedge clk);
    end

`ifdef SCPAD_BANK_PARITY_EN
    do_wr(6'd9, fill(16'h00FF), '1);
    dut.u_array.g_lane[2].mem[9] = dut.u_array.g_lane[2].mem[9] ^ 17'h00001;
    exp_d = fill(16'h00FF);
    exp_d[47:32] = 16'h00FE;
    do_rd(6'd9, 4'd1, exp_d, 1'b1);
`else
    do_wr(6'd9, fill(16'h00FF), '1);
    do_rd(6'd9, 4'd1, fill(16'h00FF), 1'b0);
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
